// File: rtl/store_write_buffer_if.sv
// rtl/store_write_buffer_if.sv - store, memory-write and load-hazard signals of the store write buffer
interface store_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [AW-1:0]     st_addr;
    logic [DW-1:0]     st_data;
    logic [DW/8-1:0]   st_be;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic              mem_ack;
    logic [AW-1:0]     ld_addr;
    logic              ld_hit;

    // master: datapath and memory side driving the buffer
    modport master (
        output st_valid, st_addr, st_data, st_be, mem_ack, ld_addr,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, ld_hit
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, mem_ack, ld_addr,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be, ld_hit
    );
endinterface

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - store queue between datapath and data memory with load-hazard compare
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    store_write_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DW / 8;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q  [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];
    logic [BW-1:0] be_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign empty        = (count == '0);
    assign full         = (count == CNT_FULL);
    assign bus.st_ready = !full;
    assign bus.mem_req  = !empty;
    assign push         = bus.st_valid && !full;
    assign pop          = !empty && bus.mem_ack;

    assign bus.mem_addr  = empty ? '0 : addr_q[rd_ptr];
    assign bus.mem_wdata = empty ? '0 : data_q[rd_ptr];
    assign bus.mem_be    = empty ? '0 : be_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr]  <= bus.st_addr;
                data_q[wr_ptr]  <= bus.st_data;
                be_q[wr_ptr]    <= bus.st_be;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_ONE;
            end
            // wr_ptr != rd_ptr whenever both happen (not full), so the clear never hits the new entry
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_ONE;
            end
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // word-granular match; byte lanes are ignored so any overlap stalls the load
    always_comb begin
        bus.ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][AW-1:2] == bus.ld_addr[AW-1:2]))
                bus.ld_hit = 1'b1;
        end
    end

    logic unused_ld_low;
    assign unused_ld_low = ^bus.ld_addr[1:0];
endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       empty;
    logic       full;
    int         total;
    int         bad;

    store_write_buffer_if #(.AW(32), .DW(32)) bus ();

    store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_be    = '0;
        bus.mem_ack  = 1'b0;
        bus.ld_addr  = 32'h0000_0010;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_st_ready", bus.st_ready, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_ld_hit", bus.ld_hit, 0);

        // single store held while not acked
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0010;
        bus.st_data  = 32'h0000_0022;
        bus.st_be    = 4'hF;
        tick();
        bus.st_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("single_req", bus.mem_req, 1);
            chk("single_addr", bus.mem_addr, 32'h10);
            chk("single_wdata", bus.mem_wdata, 32'h22);
            chk("single_be", bus.mem_be, 4'hF);
            chk("single_count", count, 1);
            tick();
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("single_empty", empty, 1);
        chk("single_count0", count, 0);
        chk("single_addr0", bus.mem_addr, 0);

        // fill to full, fifth store held off
        for (int i = 1; i <= 4; i++) begin
            bus.st_valid = 1'b1;
            bus.st_addr  = 32'h0000_0200 + 32'(4 * i);
            bus.st_data  = 32'(i);
            bus.st_be    = 4'hF;
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_ready", bus.st_ready, 0);
        chk("fill_count", count, 4);
        bus.st_addr = 32'h0000_0214;
        bus.st_data = 32'd5;
        tick();
        chk("over_ignored_count", count, 4);
        chk("over_head", bus.mem_wdata, 1);
        bus.mem_ack = 1'b1;
        #1;
        chk("over_ready_on_pop", bus.st_ready, 0);
        tick();
        bus.mem_ack = 1'b0;
        chk("over_after_pop_count", count, 3);
        chk("over_after_pop_head", bus.mem_wdata, 2);
        chk("over_ready_again", bus.st_ready, 1);
        tick();
        bus.st_valid = 1'b0;
        chk("over_accept_count", count, 4);
        bus.mem_ack = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("drain_order", bus.mem_wdata, 64'(k));
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("drain_empty", empty, 1);

        // simultaneous push and pop with one entry held
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0300;
        bus.st_data  = 32'h0000_00A0;
        tick();
        bus.st_addr  = 32'h0000_0304;
        bus.st_data  = 32'h0000_00B0;
        bus.mem_ack  = 1'b1;
        #1;
        chk("sim_ready", bus.st_ready, 1);
        tick();
        bus.st_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        chk("sim_count", count, 1);
        chk("sim_head", bus.mem_wdata, 32'hB0);
        chk("sim_head_addr", bus.mem_addr, 32'h304);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("sim_empty", empty, 1);

        // back-to-back stream across pointer wrap
        bus.mem_ack  = 1'b1;
        bus.st_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.st_addr = 32'h0000_0400 + 32'(4 * i);
            bus.st_data = 32'h0000_1000 + 32'(i);
            tick();
            chk("wrap_data", bus.mem_wdata, 64'(32'h0000_1000 + 32'(i)));
            chk("wrap_count_le2", 64'(count <= 3'd2), 1);
        end
        bus.st_valid = 1'b0;
        tick();
        bus.mem_ack = 1'b0;
        chk("wrap_empty", empty, 1);

        // load hazard at word granularity
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0104;
        bus.st_data  = 32'h0000_0055;
        bus.st_be    = 4'h1;
        bus.ld_addr  = 32'h0000_0104;
        #1;
        chk("hz_not_yet", bus.ld_hit, 0);
        tick();
        bus.st_valid = 1'b0;
        bus.ld_addr  = 32'h0000_0107;
        #1;
        chk("hz_same_word", bus.ld_hit, 1);
        bus.ld_addr = 32'h0000_0108;
        #1;
        chk("hz_next_word", bus.ld_hit, 0);
        bus.ld_addr = 32'h0000_0104;
        bus.mem_ack = 1'b1;
        #1;
        chk("hz_pop_cycle", bus.ld_hit, 1);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        chk("hz_after_ack", bus.ld_hit, 0);

        // asynchronous reset with two entries queued
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0500;
        bus.st_data  = 32'h0000_0077;
        bus.st_be    = 4'hF;
        tick();
        bus.st_addr  = 32'h0000_0504;
        tick();
        bus.st_valid = 1'b0;
        chk("pre_rst_count", count, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_mem_req", bus.mem_req, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_st_ready", bus.st_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_no_reissue", bus.mem_req, 0);
        chk("post_rst_ld_hit", bus.ld_hit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
